// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin byte scheduler sharing one UART serializer between N FIFOs
module uart_tx_sched #(
    parameter int N     = 2,
    parameter int BURST = 4,
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               res,
    input  logic [N-1:0]       src_en,
    input  logic [N-1:0]       src_empty,
    input  logic [N*WIDTH-1:0] src_data,
    output logic [N-1:0]       src_ren_n,
    output logic [N-1:0]       gnt,
    output logic [WIDTH-1:0]   tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy
);

    // Pointer is at least one bit wide so N=1 still has a legal (constant zero) register.
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    // One spare bit so BURST-1 is always representable without wrap.
    localparam int BW = $clog2(BURST) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        LATCH = 2'd2,
        SEND  = 2'd3
    } state_t;

    state_t           state_q;
    logic [N-1:0]     gnt_q;
    logic [N-1:0]     ren_n_q;
    logic [WIDTH-1:0] tx_data_q;
    logic             tx_valid_q;
    logic [PW-1:0]    g_q;
    logic [PW-1:0]    rr_ptr_q;
    logic [BW-1:0]    burst_cnt_q;

    logic [N-1:0]     req;
    logic             req_g;
    logic             pick_vld;
    logic [PW-1:0]    pick_idx;
    logic [WIDTH-1:0] sel_data;

    assign req   = src_en & ~src_empty;
    // Grant is one-hot, so the granted source's request is just the masked OR.
    assign req_g = |(req & gnt_q);

    // First requesting source at or after rr_ptr, wrapping modulo N.
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr_q) + k) % N;
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(idx);
            end
        end
    end

    // Read data of the currently granted source, selected by the one-hot grant.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_q[i]) begin
                sel_data = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Scheduler FSM; every output is a register so the serializer and FIFOs see clean edges.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            ren_n_q     <= '1;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            g_q         <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        // Read enable goes low together with entering READ, so the pulse
                        // occupies exactly the READ cycle.
                        gnt_q       <= N'(1) << pick_idx;
                        ren_n_q     <= ~(N'(1) << pick_idx);
                        g_q         <= pick_idx;
                        burst_cnt_q <= '0;
                        state_q     <= READ;
                    end
                end
                READ: begin
                    ren_n_q <= '1;
                    state_q <= LATCH;
                end
                LATCH: begin
                    // FIFO read data is valid one cycle after its read pulse.
                    tx_data_q  <= sel_data;
                    tx_valid_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    if (tx_valid_q && tx_ready) begin
                        tx_valid_q <= 1'b0;
                        if ((int'(burst_cnt_q) < BURST - 1) && req_g) begin
                            burst_cnt_q <= burst_cnt_q + BW'(1);
                            ren_n_q     <= ~gnt_q;
                            state_q     <= READ;
                        end else begin
                            rr_ptr_q <= (int'(g_q) == N - 1) ? '0 : g_q + PW'(1);
                            gnt_q    <= '0;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign src_ren_n = ren_n_q;
    assign gnt       = gnt_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed bench for uart_tx_sched (N=2/BURST=4 and N=3/BURST=1 instances)
module tb_uart_tx_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic res_a, res_b, rdy_a, rdy_b;

    logic [1:0]  a_en = 2'b11;
    logic [1:0]  a_empty, a_ren_n, a_gnt;
    logic [15:0] a_data;
    logic [7:0]  a_txd;
    logic        a_txv, a_busy;

    logic [2:0]  b_en = 3'b101;
    logic [2:0]  b_empty, b_ren_n, b_gnt;
    logic [23:0] b_data;
    logic [7:0]  b_txd;
    logic        b_txv, b_busy;

    uart_tx_sched #(.N(2), .BURST(4), .WIDTH(8)) dut_a (
        .clk(clk), .res(res_a), .src_en(a_en), .src_empty(a_empty), .src_data(a_data),
        .src_ren_n(a_ren_n), .gnt(a_gnt), .tx_data(a_txd), .tx_valid(a_txv),
        .tx_ready(rdy_a), .busy(a_busy)
    );

    uart_tx_sched #(.N(3), .BURST(1), .WIDTH(8)) dut_b (
        .clk(clk), .res(res_b), .src_en(b_en), .src_empty(b_empty), .src_data(b_data),
        .src_ren_n(b_ren_n), .gnt(b_gnt), .tx_data(b_txd), .tx_valid(b_txv),
        .tx_ready(rdy_b), .busy(b_busy)
    );

    // FIFO models: sources 0,1 feed dut_a, sources 2,3,4 feed dut_b.
    logic [7:0] mem [0:4][0:31];
    int         wr [5] = '{default: 0};
    int         rd [5] = '{default: 0};
    int         pops [5] = '{default: 0};
    logic [7:0] dreg [5] = '{default: 8'h00};
    int         bad_pop = 0;
    int         wide = 0;
    int         multi = 0;
    logic [1:0] a_prev = 2'b11;
    logic [2:0] b_prev = 3'b111;
    logic [4:0] ren_all;

    logic [7:0] log_a [$];
    logic [1:0] glog_a [$];
    logic [7:0] log_b [$];
    logic [2:0] glog_b [$];

    int vectors = 0;
    int miscompares = 0;

    assign ren_all = {b_ren_n, a_ren_n};
    assign a_empty = {rd[1] == wr[1], rd[0] == wr[0]};
    assign b_empty = {rd[4] == wr[4], rd[3] == wr[3], rd[2] == wr[2]};
    assign a_data  = {dreg[1], dreg[0]};
    assign b_data  = {dreg[4], dreg[3], dreg[2]};

    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (!ren_all[i]) begin
                pops[i] <= pops[i] + 1;
                if (rd[i] == wr[i]) begin
                    bad_pop <= bad_pop + 1;
                end else begin
                    dreg[i] <= mem[i][rd[i] % 32];
                    rd[i]   <= rd[i] + 1;
                end
            end
        end
        if (((~a_ren_n & ~a_prev) != 2'b00) || ((~b_ren_n & ~b_prev) != 3'b000)) wide <= wide + 1;
        if ($countones(~a_ren_n) > 1 || $countones(~b_ren_n) > 1) multi <= multi + 1;
        a_prev <= a_ren_n;
        b_prev <= b_ren_n;
        if (!res_a && a_txv && rdy_a) begin
            log_a.push_back(a_txd);
            glog_a.push_back(a_gnt);
        end
        if (!res_b && b_txv && rdy_b) begin
            log_b.push_back(b_txd);
            glog_b.push_back(b_gnt);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put(input int s, input string str);
        for (int k = 0; k < str.len(); k++) begin
            mem[s][wr[s] % 32] = str[k];
            wr[s]++;
        end
    endtask

    task automatic wait_log(input int which, input int want);
        int t;
        t = 0;
        while (t < 2000 && !((which == 0) ? (log_a.size() >= want && !a_busy)
                                          : (log_b.size() >= want && !b_busy))) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("wait_done_%0d", which), 32'(t < 2000), 32'd1);
    endtask

    task automatic wait_valid_a();
        int t;
        t = 0;
        while (t < 200 && !a_txv) begin
            @(negedge clk);
            t++;
        end
        chk("wait_txvalid", 32'(t < 200), 32'd1);
    endtask

    task automatic expect_log(input string tag, input int which, input int base,
                              input string bytes, input string srcs);
        int n;
        n = (which == 0) ? log_a.size() : log_b.size();
        chk($sformatf("%s_count", tag), 32'(n - base), 32'(bytes.len()));
        for (int k = 0; k < bytes.len(); k++) begin
            logic [7:0] ob;
            logic [2:0] og;
            ob = 8'hee;
            og = 3'b111;
            if (base + k < n) begin
                if (which == 0) begin
                    ob = log_a[base + k];
                    og = {1'b0, glog_a[base + k]};
                end else begin
                    ob = log_b[base + k];
                    og = glog_b[base + k];
                end
            end
            chk($sformatf("%s_byte%0d", tag, k), 32'(ob), 32'(bytes[k]));
            chk($sformatf("%s_gnt%0d", tag, k), 32'(og), 32'(1) << (srcs[k] - 8'h30));
        end
    endtask

    task automatic pulse_res_a();
        res_a = 1'b1;
        tick(1);
        res_a = 1'b0;
        tick(1);
    endtask

    initial begin
        int base;
        int p0;
        int hold_ok;
        logic [7:0] d0;

        res_a = 1'b1;
        res_b = 1'b1;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        tick(2);

        // reset state
        chk("rst_txv", 32'(a_txv), 32'd0);
        chk("rst_gnt", 32'(a_gnt), 32'd0);
        chk("rst_ren", 32'(a_ren_n), 32'h3);
        chk("rst_txd", 32'(a_txd), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_ren_b", 32'(b_ren_n), 32'h7);
        res_a = 1'b0;
        res_b = 1'b0;
        tick(1);

        // single source with latency: IDLE sample, ren low +1, tx_valid +3
        base = log_a.size();
        put(0, "abc");
        tick(1);
        chk("lat1_ren", 32'(a_ren_n), 32'h2);
        chk("lat1_gnt", 32'(a_gnt), 32'h1);
        chk("lat1_txv", 32'(a_txv), 32'd0);
        chk("lat1_busy", 32'(a_busy), 32'd1);
        tick(1);
        chk("lat2_ren", 32'(a_ren_n), 32'h3);
        chk("lat2_txv", 32'(a_txv), 32'd0);
        tick(1);
        chk("lat3_txv", 32'(a_txv), 32'd1);
        chk("lat3_txd", 32'(a_txd), 32'(8'h61));
        wait_log(0, base + 3);
        expect_log("single", 0, base, "abc", "000");
        chk("single_gnt_idle", 32'(a_gnt), 32'd0);
        chk("single_pops0", 32'(pops[0]), 32'd3);
        chk("single_pops1", 32'(pops[1]), 32'd0);

        // burst fairness
        pulse_res_a();
        base = log_a.size();
        put(0, "abcdef");
        put(1, "0123");
        wait_log(0, base + 10);
        expect_log("burst", 0, base, "abcd0123ef", "0000111100");

        // backpressure
        pulse_res_a();
        rdy_a = 1'b0;
        base = log_a.size();
        put(0, "pq");
        wait_valid_a();
        p0 = pops[0] + pops[1];
        d0 = a_txd;
        hold_ok = 1;
        repeat (100) begin
            @(negedge clk);
            if (a_txd !== d0 || a_txv !== 1'b1) hold_ok = 0;
        end
        chk("bp_stable", 32'(hold_ok), 32'd1);
        chk("bp_data", 32'(d0), 32'(8'h70));
        chk("bp_no_reads", 32'(pops[0] + pops[1]), 32'(p0));
        chk("bp_no_hs", 32'(log_a.size()), 32'(base));
        rdy_a = 1'b1;
        wait_log(0, base + 2);
        tick(10);
        expect_log("bp", 0, base, "pq", "00");

        // empty mid-burst: early rotation
        pulse_res_a();
        base = log_a.size();
        put(0, "gh");
        put(1, "xyz");
        wait_log(0, base + 5);
        expect_log("early", 0, base, "ghxyz", "00111");
        chk("early_bad_pop", 32'(bad_pop), 32'd0);

        // reset mid-SEND with rr_ptr pointing at src1
        pulse_res_a();
        base = log_a.size();
        put(0, "k");
        wait_log(0, base + 1);
        rdy_a = 1'b0;
        put(0, "mM");
        put(1, "nN");
        wait_valid_a();
        chk("pre_rst_txd", 32'(a_txd), 32'(8'h6e));
        chk("pre_rst_gnt", 32'(a_gnt), 32'h2);
        res_a = 1'b1;
        #1;
        chk("mid_rst_txv", 32'(a_txv), 32'd0);
        chk("mid_rst_gnt", 32'(a_gnt), 32'd0);
        chk("mid_rst_ren", 32'(a_ren_n), 32'h3);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        chk("mid_rst_txd", 32'(a_txd), 32'd0);
        tick(2);
        res_a = 1'b0;
        rdy_a = 1'b1;
        base = log_a.size();
        wait_log(0, base + 3);
        expect_log("restart", 0, base, "mMN", "001");

        // N=3, mask 101, BURST=1
        base = log_b.size();
        put(2, "12");
        put(3, "55");
        put(4, "89");
        wait_log(1, base + 4);
        expect_log("mask", 1, base, "1829", "0202");
        chk("mask_src1_reads", 32'(pops[3]), 32'd0);
        chk("mask_gnt_idle", 32'(b_gnt), 32'd0);

        tick(2);
        chk("ren_pulse_width", 32'(wide), 32'd0);
        chk("ren_one_hot", 32'(multi), 32'd0);
        chk("no_empty_reads", 32'(bad_pop), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
